// File: rtl/inst_rom.sv
// Instruction ROM with a byte-stream loader.
// The core fetches combinationally; a loader fills words big-endian.
module inst_rom #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [31:0]       addr,
    output logic [31:0]       inst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic [ADDR_W:0]   ld_words,
    output logic              ld_full
);

    localparam int unsigned    DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [ADDR_W-1:0]   r_wptr;
    logic [1:0]          r_bcnt;
    logic [23:0]         r_acc;
    logic [ADDR_W:0]     r_words;
    logic                r_full;
    logic [31:0]         r_mem [0:DEPTH-1];

    logic                w_accept;
    logic                w_word_done;
    logic                w_flush;
    logic                w_we;
    logic                w_at_end;
    logic                w_clear;
    logic [31:0]         w_wdata;
    logic [ADDR_W-1:0]   w_rd_idx;
    logic                w_unused_addr;

    // Loader handshake and write qualification
    assign w_accept    = (r_state == S_LOAD) && ld_valid && !ld_start;
    assign w_word_done = w_accept && (r_bcnt == 2'd3);
    assign w_flush     = (r_state == S_FLUSH);
    assign w_we        = w_word_done || w_flush;
    assign w_at_end    = (r_wptr == {ADDR_W{1'b1}});
    assign w_clear     = ld_start && (r_state != S_FLUSH);

    assign ld_ready = (r_state == S_LOAD);
    assign ld_busy  = (r_state != S_IDLE);
    assign ld_words = r_words;
    assign ld_full  = r_full;

    // Fetch port: byte offset and bits above the depth are ignored
    assign w_rd_idx      = addr[ADDR_W+1:2];
    assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
    assign inst = (ce && (r_state == S_IDLE)) ? r_mem[w_rd_idx] : NOP_WORD;

    // Word to store: full word on 4th byte, zero-padded partial on flush
    always_comb begin
        w_wdata = {r_acc, ld_data};
        if (w_flush) begin
            unique case (r_bcnt)
                2'd1:    w_wdata = {r_acc[7:0], 24'h0};
                2'd2:    w_wdata = {r_acc[15:0], 16'h0};
                2'd3:    w_wdata = {r_acc, 8'h0};
                default: w_wdata = 32'h0;
            endcase
        end
    end

    // Loader next-state logic
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (ld_start) begin
                    w_state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ld_start) begin
                    w_state_nx = S_LOAD;
                end else if (w_word_done && (ld_last || w_at_end)) begin
                    w_state_nx = S_IDLE;
                end else if (w_accept && ld_last && !w_word_done) begin
                    w_state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Loader state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Byte assembly, write pointer, word count and full flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_bcnt  <= 2'd0;
            r_acc   <= 24'h0;
            r_words <= '0;
            r_full  <= 1'b0;
        end else if (w_clear) begin
            r_wptr  <= '0;
            r_bcnt  <= 2'd0;
            r_acc   <= 24'h0;
            r_words <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc  <= {r_acc[15:0], ld_data};
                r_bcnt <= r_bcnt + 2'd1;
            end
            if (w_flush) begin
                r_acc  <= 24'h0;
                r_bcnt <= 2'd0;
            end
            if (w_we) begin
                r_wptr  <= r_wptr + PTR_ONE;
                r_words <= r_words + CNT_ONE;
                if (w_at_end) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

    // Storage array, deliberately not reset so contents survive rst
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_inst_rom.sv
// Bench for inst_rom: directed tables, corner sequences, random sessions.
// A second instance with ADDR_W=2 exercises the full condition.
module tb_inst_rom;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h0;
    logic        ld_last = 1'b0;

    logic [31:0] inst;
    logic        ld_ready, ld_busy, ld_full;
    logic [10:0] ld_words;
    logic [31:0] s_inst;
    logic        s_ready, s_busy, s_full;
    logic [2:0]  s_words;

    inst_rom #(.ADDR_W(10), .NOP_WORD(32'h0)) u_dut (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .ld_busy(ld_busy),
        .ld_words(ld_words), .ld_full(ld_full)
    );

    inst_rom #(.ADDR_W(2), .NOP_WORD(32'h0)) u_small (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(s_inst),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(s_ready), .ld_busy(s_busy),
        .ld_words(s_words), .ld_full(s_full)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] mem_m [1024];
    bit          vld_m [1024];
    logic [7:0]  sess_q [$];

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ld_start pulse with a junk byte that must never be taken
    task automatic start();
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'hC3;
        ld_last  = 1'b0;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Commit the bytes of sess_q into the model: whole words always,
    // a zero-padded tail only if the session ended with ld_last.
    task automatic model_commit(input bit completed);
        int n, nw;
        logic [31:0] w;
        n  = sess_q.size();
        nw = completed ? (n + 3) / 4 : n / 4;
        for (int k = 0; k < nw; k++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++)
                if (4 * k + b < n) w[31 - 8 * b -: 8] = sess_q[4 * k + b];
            mem_m[k] = w;
            vld_m[k] = 1'b1;
        end
    endtask

    task automatic rd(input string name, input logic c, input logic [31:0] a,
                      input logic [31:0] exp);
        ce   = c;
        addr = a;
        #1;
        chk(name, inst, exp);
    endtask

    task automatic rand_session();
        int k, n, idx;
        logic [31:0] a;
        logic        c;
        sess_q.delete();
        if ($urandom_range(0, 2) == 0) begin
            k = $urandom_range(1, 9);
            start();
            for (int i = 0; i < k; i++) begin
                sess_q.push_back(8'($urandom));
                send(sess_q[i], 1'b0);
            end
            model_commit(1'b0);
            sess_q.delete();
        end
        start();
        rd("rnd_nop_busy", 1'b1, $urandom, 32'h0);
        n = $urandom_range(1, 24);
        for (int i = 0; i < n; i++) begin
            sess_q.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
            send(sess_q[i], i == n - 1);
        end
        model_commit(1'b1);
        if ($urandom_range(0, 1) == 1) begin
            ld_valid = 1'b1;
            ld_data  = 8'($urandom);
        end
        for (int c2 = 0; c2 < 4 && ld_busy; c2++) tick();
        ld_valid = 1'b0;
        chk("rnd_busy_end", {31'h0, ld_busy}, 32'h0);
        chk("rnd_words", {21'h0, ld_words}, 32'((n + 3) / 4));
        for (int r = 0; r < 4; r++) begin
            idx = $urandom_range(0, 7);
            if (!vld_m[idx]) idx = 0;
            a = $urandom;
            a[11:2] = 10'(idx);
            c = ($urandom_range(0, 3) != 0);
            rd("rnd_read", c, a, c ? mem_m[idx] : 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) vld_m[i] = 1'b0;
        vecs[0] = '{1'b1, 32'h0000_0000, 32'h1234_5678};
        vecs[1] = '{1'b1, 32'h0000_0004, 32'h9ABC_DEF0};
        vecs[2] = '{1'b1, 32'h0000_0007, 32'h9ABC_DEF0};
        vecs[3] = '{1'b1, 32'h0000_1000, 32'h1234_5678};
        vecs[4] = '{1'b1, 32'hFFFF_F006, 32'h9ABC_DEF0};
        vecs[5] = '{1'b0, 32'h0000_0004, 32'h0000_0000};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000};

        // reset state
        #12;
        chk("rst_busy", {31'h0, ld_busy}, 32'h0);
        chk("rst_ready", {31'h0, ld_ready}, 32'h0);
        chk("rst_words", {21'h0, ld_words}, 32'h0);
        chk("rst_full", {31'h0, ld_full}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        #5 rst = 1'b1;
        tick();

        // two full words, last on a 4th byte
        start();
        chk("l1_busy", {31'h0, ld_busy}, 32'h1);
        chk("l1_ready", {31'h0, ld_ready}, 32'h1);
        chk("l1_words0", {21'h0, ld_words}, 32'h0);
        rd("l1_nop_load", 1'b1, 32'h0, 32'h0);
        send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
        send(8'h9A, 0); send(8'hBC, 0); send(8'hDE, 0); send(8'hF0, 1);
        chk("l1_idle", {31'h0, ld_busy}, 32'h0);
        chk("l1_words", {21'h0, ld_words}, 32'h2);
        rd("l1_same_cycle", 1'b1, 32'h4, 32'h9ABC_DEF0);
        for (int i = 0; i < 7; i++)
            rd($sformatf("tbl%0d", i), vecs[i].ce, vecs[i].addr, vecs[i].exp);
        tick();
        chk("l1_words_hold", {21'h0, ld_words}, 32'h2);

        // partial word flush, ld_start during flush is ignored
        start();
        send(8'hAA, 0); send(8'hBB, 1);
        chk("fl_busy", {31'h0, ld_busy}, 32'h1);
        chk("fl_ready", {31'h0, ld_ready}, 32'h0);
        rd("fl_nop", 1'b1, 32'h0, 32'h0);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("fl_start_ign", {31'h0, ld_busy}, 32'h0);
        chk("fl_words", {21'h0, ld_words}, 32'h1);
        rd("fl_mem0", 1'b1, 32'h0, 32'hAABB_0000);
        rd("fl_mem1", 1'b1, 32'h4, 32'h9ABC_DEF0);

        // restart mid-session discards the partial word
        start();
        send(8'h11, 0); send(8'h22, 0);
        start();
        send(8'h33, 0); send(8'h44, 0); send(8'h55, 0); send(8'h66, 1);
        chk("rs_words", {21'h0, ld_words}, 32'h1);
        rd("rs_mem0", 1'b1, 32'h0, 32'h3344_5566);
        rd("rs_mem1", 1'b1, 32'h4, 32'h9ABC_DEF0);

        // asynchronous reset mid-load
        start();
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
        send(8'h04, 0); send(8'h05, 0); send(8'h06, 0);
        chk("ar_words_pre", {21'h0, ld_words}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("ar_busy", {31'h0, ld_busy}, 32'h0);
        chk("ar_ready", {31'h0, ld_ready}, 32'h0);
        chk("ar_words", {21'h0, ld_words}, 32'h0);
        chk("ar_full", {31'h0, ld_full}, 32'h0);
        #2 rst = 1'b1;
        tick();
        rd("ar_mem0", 1'b1, 32'h0, 32'h0102_0304);
        rd("ar_mem1", 1'b1, 32'h4, 32'h9ABC_DEF0);
        start();
        send(8'h77, 0); send(8'h88, 0); send(8'h99, 0); send(8'hAA, 1);
        chk("ar_reload_words", {21'h0, ld_words}, 32'h1);
        rd("ar_reload_mem0", 1'b1, 32'h0, 32'h7788_99AA);

        // fill the 4-word instance
        start();
        sess_q.delete();
        for (int i = 0; i < 16; i++) begin
            sess_q.push_back(8'(8'h10 + i));
            if (i == 15) chk("sm_full_before", {31'h0, s_full}, 32'h0);
            send(sess_q[i], 1'b0);
        end
        chk("sm_full", {31'h0, s_full}, 32'h1);
        chk("sm_ready", {31'h0, s_ready}, 32'h0);
        chk("sm_busy", {31'h0, s_busy}, 32'h0);
        chk("sm_words", {29'h0, s_words}, 32'h4);
        send(8'hEE, 0);
        chk("sm_words_17", {29'h0, s_words}, 32'h4);
        ce = 1'b1;
        addr = 32'h10;
        #1;
        chk("sm_wrap0", s_inst, 32'h1011_1213);
        addr = 32'hC;
        #1;
        chk("sm_mem3", s_inst, 32'h1C1D_1E1F);
        chk("big_not_full", {31'h0, ld_full}, 32'h0);
        chk("big_words4", {21'h0, ld_words}, 32'h4);
        mem_m[0] = 32'h0102_0304;
        mem_m[1] = 32'h9ABC_DEF0;
        vld_m[0] = 1'b1;
        vld_m[1] = 1'b1;
        model_commit(1'b0);
        #2 rst = 1'b0;
        #3 rst = 1'b1;
        tick();

        // random sessions against the model
        for (int s = 0; s < 30; s++) rand_session();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 SHALL have parameter: ADDR_W, 10, log2 of memory depth in 32-bit words (default 1024 words).
REQ-002 SHALL have parameter: NOP_WORD, 32'h00000000, value driven on inst while fetch is disabled or loader busy.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: ce  input  1  fetch enable from the core's PC stage.
REQ-006 SHALL have port: addr  input  32  fetch byte address from the core.
REQ-007 SHALL have port: inst  output  32  fetched instruction word to the core.
REQ-008 SHALL have port: ld_start  input  1  single-cycle pulse; opens or restarts a load session.
REQ-009 SHALL have port: ld_valid  input  1  loader byte valid.
REQ-010 SHALL have port: ld_data  input  8  loader byte.
REQ-011 SHALL have port: ld_last  input  1  marks the accepted byte as the final byte of the session.
REQ-012 SHALL have port: ld_ready  output  1  loader byte accept; a byte transfers on a rising edge with ld_valid=1 and ld_ready=1.
REQ-013 SHALL have port: ld_busy  output  1  high while a load session is open.
REQ-014 SHALL have port: ld_words  output  ADDR_W+1  number of words written in the current or last session.
REQ-015 SHALL have port: ld_full  output  1  sticky; the last memory location was written.

Function
REQ-016 SHALL hold a 2^ADDR_W x 32 array; word index = addr[ADDR_W+1:2]; addr[1:0] and addr bits above ADDR_W+1 ignored (wrap modulo depth).
REQ-017 SHALL drive inst combinationally in the same cycle: mem[index] when ce=1 and ld_busy=0, else NOP_WORD (matches the core's same-edge registration of PC and instruction).
REQ-018 SHALL implement loader FSM states IDLE, LOAD, FLUSH; ld_ready = (state==LOAD); ld_busy = (state!=IDLE).
REQ-019 IDLE: ld_start -> LOAD with write pointer 0, byte count 0, ld_words 0, ld_full 0; ld_valid ignored in IDLE, including in the ld_start cycle.
REQ-020 LOAD: each accepted byte fills lanes big-endian (1st byte -> [31:24], 4th -> [7:0]); byte count 0..3 wraps.
REQ-021 On the 4th accepted byte, SHALL write the assembled word to mem[wptr] at that same edge, increment wptr and ld_words.
REQ-022 ld_last on a 4th byte: word written, next state IDLE; ld_last on byte 1..3: next state FLUSH.
REQ-023 FLUSH: one cycle; writes the partial word with unfilled lanes 0, increments ld_words, returns to IDLE; ld_ready=0.
REQ-024 A word write to index 2^ADDR_W-1 SHALL set ld_full and force IDLE regardless of ld_last; following bytes are not accepted.
REQ-025 ld_start in LOAD SHALL restart the session (wptr, byte count, ld_words, ld_full cleared, partial word discarded, no byte accepted that cycle); ld_start in FLUSH SHALL complete the flush, then be ignored.
REQ-026 ld_words SHALL hold its value in IDLE until the next ld_start.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, wptr 0, byte count 0, ld_words 0, ld_full 0, ld_ready 0, ld_busy 0.
REQ-028 Memory contents SHALL NOT be reset; reset mid-load keeps already written words and drops the partial word.
REQ-029 inst after reset SHALL follow REQ-017 with no extra delay.

Verification
REQ-030 ld_start; bytes 12 34 56 78 9A BC DE F0 (last on F0) -> mem[0]=32'h12345678, mem[1]=32'h9ABCDEF0, ld_words=2, back to IDLE; ce=1, addr=0x4 -> inst=32'h9ABCDEF0 same cycle.
REQ-031 ld_start; bytes AA BB (last on BB) -> one FLUSH cycle, mem[0]=32'hAABB0000, ld_words=1.
REQ-032 During LOAD, ce=1 addr=0 -> inst=NOP_WORD; after return to IDLE -> stored word; ce=0 -> NOP_WORD.
REQ-033 ADDR_W=2: 16 bytes without ld_last -> ld_full=1 after 4th word, ld_ready=0, 17th byte not written, addr=0x10 reads mem[0].
REQ-034 ld_start, bytes 11 22, ld_start, bytes 33 44 55 66 (last) -> mem[0]=32'h33445566, ld_words=1.
REQ-035 Reset asserted after 6 bytes of a load -> mem[0] kept, partial word dropped, all loader outputs 0 asynchronously, ld_start restarts normally.
